// File: rtl/dropout_mask_gen_if.sv
// Request/mask bus between the dropout controller and the mask generator.
// The master drives control and ready; the slave returns the mask, its keep count and busy.
interface dropout_mask_gen_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LFSR_W = 16
);
  logic                         ena;
  logic [7:0]                   rate_in;
  logic                         rate_we;
  logic [LFSR_W-1:0]            seed_in;
  logic                         seed_we;
  logic                         mask_ready;
  logic                         mask_valid;
  logic [LANES-1:0]             mask;
  logic [$clog2(LANES+1)-1:0]   keep_cnt;
  logic                         busy;

  modport master (
    output ena, rate_in, rate_we, seed_in, seed_we, mask_ready,
    input  mask_valid, mask, keep_cnt, busy
  );

  modport slave (
    input  ena, rate_in, rate_we, seed_in, seed_we, mask_ready,
    output mask_valid, mask, keep_cnt, busy
  );
endinterface

// File: rtl/dropout_mask_gen.sv
// Per-neuron dropout keep-mask generator: a Galois LFSR byte is compared with a
// snapshotted drop threshold once per lane, and the finished mask is offered on valid/ready.
module dropout_mask_gen #(
  parameter int unsigned     LANES        = 8,
  parameter int unsigned     LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter logic [7:0]      DEFAULT_RATE = 8'h80
) (
  input  logic               clk,
  input  logic               rst_n,
  dropout_mask_gen_if.slave  bus
);

  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned KC_W  = $clog2(LANES+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LFSR_W-1:0] r_lfsr;
  logic [7:0]        r_rate_q;
  logic [7:0]        r_rate_gen;
  logic [CNT_W-1:0]  r_lane;
  logic [LANES-1:0]  r_shadow;
  logic [LANES-1:0]  r_mask;
  logic [KC_W-1:0]   r_keep_cnt;
  logic              r_mask_valid;

  logic              w_handshake;
  logic              w_last_lane;
  logic              w_keep;
  logic              w_start;
  logic              w_step;
  logic              w_done;
  logic [LFSR_W-1:0] w_lfsr_step;
  logic [LANES-1:0]  w_shadow_nxt;
  logic [KC_W-1:0]   w_pop;

  assign w_handshake = r_mask_valid & bus.mask_ready;
  assign w_last_lane = (r_lane == CNT_W'(LANES-1));
  assign w_keep      = (r_lfsr[7:0] >= r_rate_gen);
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  always_comb begin
    w_shadow_nxt         = r_shadow;
    w_shadow_nxt[r_lane] = w_keep;
    w_pop                = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_pop = w_pop + KC_W'(w_shadow_nxt[i]);
    end
  end

  // A seed write overrides every transition, including the HOLD auto-restart.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_done      = 1'b0;
    if (bus.seed_we) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.ena) begin
            w_state_nxt = S_GEN;
            w_start     = 1'b1;
          end
        end
        S_GEN: begin
          if (bus.ena) begin
            w_step = 1'b1;
            if (w_last_lane) begin
              w_state_nxt = S_HOLD;
              w_done      = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_handshake) begin
            if (bus.ena) begin
              w_state_nxt = S_GEN;
              w_start     = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lfsr       <= SEED;
      r_rate_q     <= DEFAULT_RATE;
      r_rate_gen   <= DEFAULT_RATE;
      r_lane       <= '0;
      r_shadow     <= '0;
      r_mask       <= '0;
      r_keep_cnt   <= '0;
      r_mask_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.rate_we) begin
        r_rate_q <= bus.rate_in;
      end
      if (bus.seed_we) begin
        r_lfsr       <= (bus.seed_in == '0) ? SEED : bus.seed_in;
        r_lane       <= '0;
        r_shadow     <= '0;
        r_mask_valid <= 1'b0;
      end else begin
        if (w_start) begin
          r_lane     <= '0;
          r_shadow   <= '0;
          r_rate_gen <= r_rate_q;
        end
        if (w_step) begin
          r_lfsr   <= w_lfsr_step;
          r_lane   <= r_lane + CNT_W'(1);
          r_shadow <= w_shadow_nxt;
        end
        if (w_done) begin
          r_mask       <= w_shadow_nxt;
          r_keep_cnt   <= w_pop;
          r_mask_valid <= 1'b1;
        end else if (w_handshake) begin
          r_mask_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.mask_valid = r_mask_valid;
  assign bus.mask       = r_mask;
  assign bus.keep_cnt   = r_keep_cnt;
  assign bus.busy       = (r_state == S_GEN);

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Directed bench for dropout_mask_gen: a table of seed/rate runs plus hand-written
// sequences for stalls, seed aborts, back-to-back masks and asynchronous reset.
module tb_dropout_mask_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dropout_mask_gen_if u_if ();

  dropout_mask_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [7:0]  rate;
    logic        rate_w;
    logic [15:0] seed;
    logic        seed_w;
    logic [7:0]  exp_mask;
    logic [3:0]  exp_cnt;
    logic [15:0] exp_lfsr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    u_if.ena        = 1'b0;
    u_if.rate_in    = 8'h00;
    u_if.rate_we    = 1'b0;
    u_if.seed_in    = 16'h0000;
    u_if.seed_we    = 1'b0;
    u_if.mask_ready = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic ref_mask(input logic [15:0] seed, input logic [7:0] rate,
                          output logic [7:0] m, output logic [3:0] c);
    logic [15:0] s;
    s = seed;
    m = '0;
    c = '0;
    for (int k = 0; k < 8; k++) begin
      if (s[7:0] >= rate) begin
        m[k] = 1'b1;
        c    = c + 4'd1;
      end
      s = lfsr_step(s);
    end
  endtask

  initial begin
    logic [7:0] rm;
    logic [3:0] rc;
    int         gap;
    logic       seen;

    vecs[0] = '{"default",     8'h80, 1'b0, 16'hACE1, 1'b0, 8'h89, 4'd3, 16'hC2C4};
    vecs[1] = '{"rate00",      8'h00, 1'b1, 16'hACE1, 1'b0, 8'hFF, 4'd8, 16'hC2C4};
    vecs[2] = '{"rateFF",      8'hFF, 1'b1, 16'hACE1, 1'b0, 8'h00, 4'd0, 16'hC2C4};
    vecs[3] = '{"rate40",      8'h40, 1'b1, 16'hACE1, 1'b0, 8'h9B, 4'd5, 16'hC2C4};
    vecs[4] = '{"rateE1",      8'hE1, 1'b1, 16'hACE1, 1'b0, 8'h01, 4'd1, 16'hC2C4};
    vecs[5] = '{"rateE2",      8'hE2, 1'b1, 16'hACE1, 1'b0, 8'h00, 4'd0, 16'hC2C4};
    vecs[6] = '{"seedC2C4",    8'h80, 1'b0, 16'hC2C4, 1'b1, 8'hC5, 4'd4, 16'hEB62};
    vecs[7] = '{"seed0_rate0", 8'h00, 1'b1, 16'h0000, 1'b1, 8'hFF, 4'd8, 16'hC2C4};

    // Reset state
    do_reset();
    check("rst_valid", 32'(u_if.mask_valid), 32'd0);
    check("rst_mask",  32'(u_if.mask),       32'h00);
    check("rst_cnt",   32'(u_if.keep_cnt),   32'd0);
    check("rst_busy",  32'(u_if.busy),       32'd0);
    check("rst_lfsr",  32'(dut.r_lfsr),      32'hACE1);

    // Table-driven runs: optional config write in IDLE, then one mask with ready low
    foreach (vecs[i]) begin
      do_reset();
      u_if.rate_in = vecs[i].rate;
      u_if.rate_we = vecs[i].rate_w;
      u_if.seed_in = vecs[i].seed;
      u_if.seed_we = vecs[i].seed_w;
      tick(1);
      u_if.rate_we = 1'b0;
      u_if.seed_we = 1'b0;
      u_if.ena     = 1'b1;
      tick(8);
      check({vecs[i].name, "_early"}, 32'(u_if.mask_valid), 32'd0);
      tick(1);
      check({vecs[i].name, "_valid"}, 32'(u_if.mask_valid), 32'd1);
      check({vecs[i].name, "_mask"},  32'(u_if.mask),       32'(vecs[i].exp_mask));
      check({vecs[i].name, "_cnt"},   32'(u_if.keep_cnt),   32'(vecs[i].exp_cnt));
      check({vecs[i].name, "_lfsr"},  32'(dut.r_lfsr),      32'(vecs[i].exp_lfsr));
    end

    // Default run: busy timing and a 5-cycle hold with ready low
    do_reset();
    u_if.ena = 1'b1;
    tick(1);
    check("run_busy_entry", 32'(u_if.busy), 32'd1);
    tick(8);
    check("run_valid9", 32'(u_if.mask_valid), 32'd1);
    check("run_busy_hold", 32'(u_if.busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("hold_valid", 32'(u_if.mask_valid), 32'd1);
      check("hold_mask",  32'(u_if.mask),       32'h89);
      check("hold_cnt",   32'(u_if.keep_cnt),   32'd3);
    end

    // ena low for 3 cycles after lane 3: same mask, valid 3 cycles late
    do_reset();
    u_if.ena = 1'b1;
    tick(5);
    u_if.ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("stall_busy",  32'(u_if.busy),       32'd1);
      check("stall_valid", 32'(u_if.mask_valid), 32'd0);
    end
    u_if.ena = 1'b1;
    tick(3);
    check("stall_early", 32'(u_if.mask_valid), 32'd0);
    check("stall_busy2", 32'(u_if.busy),       32'd1);
    tick(1);
    check("stall_valid12", 32'(u_if.mask_valid), 32'd1);
    check("stall_mask",    32'(u_if.mask),       32'h89);

    // Zero seed written at lane 5 aborts to IDLE with the default seed
    do_reset();
    u_if.ena = 1'b1;
    tick(6);
    u_if.seed_in = 16'h0000;
    u_if.seed_we = 1'b1;
    tick(1);
    u_if.seed_we = 1'b0;
    check("abort_valid", 32'(u_if.mask_valid), 32'd0);
    check("abort_busy",  32'(u_if.busy),       32'd0);
    check("abort_lfsr",  32'(dut.r_lfsr),      32'hACE1);
    tick(8);
    check("abort_early", 32'(u_if.mask_valid), 32'd0);
    tick(1);
    check("abort_rerun_valid", 32'(u_if.mask_valid), 32'd1);
    check("abort_rerun_mask",  32'(u_if.mask),       32'h89);

    // Back-to-back masks with ready held high: 9-cycle period
    do_reset();
    u_if.ena        = 1'b1;
    u_if.mask_ready = 1'b1;
    tick(9);
    check("b2b_valid1", 32'(u_if.mask_valid), 32'd1);
    ref_mask(16'hACE1, 8'h80, rm, rc);
    check("b2b_mask1_model", 32'(u_if.mask), 32'(rm));
    check("b2b_mask1",       32'(u_if.mask), 32'h89);
    tick(1);
    check("b2b_drop",  32'(u_if.mask_valid), 32'd0);
    check("b2b_busy",  32'(u_if.busy),       32'd1);
    gap  = 1;
    seen = 1'b0;
    while (!seen && gap < 20) begin
      tick(1);
      gap++;
      seen = u_if.mask_valid;
    end
    check("b2b_seen",   32'(seen), 32'd1);
    check("b2b_period", 32'(gap),  32'd9);
    ref_mask(16'hC2C4, 8'h80, rm, rc);
    check("b2b_mask2_model", 32'(u_if.mask),     32'(rm));
    check("b2b_cnt2_model",  32'(u_if.keep_cnt), 32'(rc));
    check("b2b_mask2",       32'(u_if.mask),     32'hC5);

    // Rate change mid-GEN applies only to the next mask; then async reset in HOLD
    do_reset();
    u_if.ena        = 1'b1;
    u_if.mask_ready = 1'b1;
    tick(3);
    u_if.rate_in = 8'h00;
    u_if.rate_we = 1'b1;
    tick(1);
    u_if.rate_we = 1'b0;
    tick(5);
    check("midrate_valid1", 32'(u_if.mask_valid), 32'd1);
    check("midrate_mask1",  32'(u_if.mask),       32'h89);
    tick(1);
    u_if.mask_ready = 1'b0;
    tick(8);
    ref_mask(16'hC2C4, 8'h00, rm, rc);
    check("midrate_valid2", 32'(u_if.mask_valid), 32'd1);
    check("midrate_mask2",  32'(u_if.mask),       32'(rm));
    check("midrate_cnt2",   32'(u_if.keep_cnt),   32'd8);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(u_if.mask_valid), 32'd0);
    check("async_mask",  32'(u_if.mask),       32'h00);
    check("async_cnt",   32'(u_if.keep_cnt),   32'd0);
    check("async_busy",  32'(u_if.busy),       32'd0);
    check("async_lfsr",  32'(dut.r_lfsr),      32'hACE1);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dropout_mask_gen.md
Name: dropout_mask_gen

Overview:
- Synthesizable per-neuron dropout mask generator; sits directly upstream of the dropout stage, replacing simulation-only random calls with a 16-bit Galois LFSR.
- Produces one 8-lane keep mask per request: bit i = 1 keeps neuron i, bit i = 0 drops it.
- Drop probability is set by a programmable 8-bit rate. Masks are delivered over a valid/ready handshake, with a keep count for downstream rescaling.

Parameters:
- LANES, 8, number of neurons per mask; the bench covers the default only.
- LFSR_W, 16, LFSR width.
- TAPS, 16'hB400, Galois feedback mask for x^16+x^14+x^13+x^11+1.
- SEED, 16'hACE1, LFSR value after reset; also substituted whenever a zero seed is written.
- DEFAULT_RATE, 8'h80, drop threshold after reset (≈50%).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  generation enable.
- rate_in  in  8  new drop threshold.
- rate_we  in  1  write strobe for rate_in.
- seed_in  in  16  new LFSR seed.
- seed_we  in  1  write strobe for seed_in.
- mask_ready  in  1  downstream accepts the mask.
- mask_valid  out  1  mask and keep_cnt are valid.
- mask  out  8  keep mask; bit i = lane i.
- keep_cnt  out  4  number of 1 bits in mask (0..8).
- busy  out  1  FSM is in GEN.

Behaviour:
- Reset values:
  - lfsr = SEED; rate_q = DEFAULT_RATE; state = IDLE.
  - mask = 0, keep_cnt = 0, mask_valid = 0, busy = 0, lane counter = 0.
  - Reset asserted mid-GEN or mid-HOLD aborts immediately to these values.
- LFSR step: if lfsr[0] = 1, lfsr <= (lfsr >> 1) ^ TAPS; otherwise lfsr <= lfsr >> 1. The LFSR advances only in GEN cycles while ena = 1.
- FSM states: IDLE, GEN, HOLD.
- IDLE:
  - ena = 1 -> GEN next cycle; lane counter = 0; rate_q is snapshotted into rate_gen.
  - ena = 0 -> stay in IDLE.
- GEN, one lane per cycle while ena = 1:
  - Lane k compares the current (pre-step) lfsr[7:0] against rate_gen, unsigned.
  - If lfsr[7:0] < rate_gen, shadow bit k = 0 (drop); otherwise shadow bit k = 1 (keep).
  - The LFSR then steps and the counter increments.
  - ena = 0 in GEN freezes the LFSR, the counter and the shadow mask; nothing is lost.
  - After lane 7 is processed: go to HOLD; mask <= shadow; keep_cnt <= popcount(shadow); mask_valid = 1.
  - Latency: mask_valid rises 8 enabled cycles after GEN entry.
- HOLD:
  - mask, keep_cnt and mask_valid stay stable until mask_valid & mask_ready.
  - On the handshake: if ena = 1, go straight to GEN (fresh rate snapshot), giving a 9-cycle period per mask. If ena = 0, go to IDLE.
  - mask_valid drops the cycle after the handshake; the mask contents are not cleared.
- Rate rules:
  - rate_we updates rate_q in any state. The new rate takes effect at the next GEN entry, never mid-mask.
  - Rate 0 -> all lanes kept (mask = 0xFF).
  - Rate 0xFF -> a lane is kept only when its byte = 0xFF.
- Seed rules:
  - seed_we loads lfsr <= seed_in, or SEED if seed_in = 0; the LFSR never enters the all-zero lockup state.
  - seed_we in any state aborts: state -> IDLE, mask_valid -> 0, shadow and counter cleared.
  - seed_we has priority over the LFSR step, the GEN transition and the auto-restart. A handshake in the same cycle still counts as consumed.
  - rate_we and seed_we in the same cycle: both take effect.
- busy = 1 exactly while state = GEN, including frozen cycles.

Test Plan:
- Reset, default seed and rate, ena = 1, mask_ready = 0:
  - Lane bytes are E1, 70, 38, 9C, 4E, 27, 13, 89.
  - Required: mask_valid = 1 at cycle 9 (1 cycle IDLE->GEN, then 8 cycles GEN), mask = 0x89, keep_cnt = 3, internal lfsr = 0xC2C4; outputs held stable for 5 cycles while ready = 0.
- rate_we with 0x00 before start, then default run -> mask = 0xFF, keep_cnt = 8. Repeat with rate 0xFF -> mask = 0x00, keep_cnt = 0.
- ena toggled low for 3 cycles mid-GEN (after lane 3) -> same mask 0x89; valid delayed by exactly 3 cycles; busy stays 1 throughout.
- seed_we with 0x0000 during GEN lane 5 -> mask_valid stays 0, FSM returns to IDLE, lfsr = 0xACE1; the next run again yields 0x89.
- mask_ready held 1 with ena = 1 -> a valid pulse every 9 cycles; second mask generated from lfsr 0xC2C4. Bench compares both masks against a reference model.
- rate_we with 0x00 during GEN of mask 1 -> mask 1 still uses 0x80 (0x89); mask 2 = 0xFF. Then assert rst_n low mid-HOLD -> all outputs 0 immediately (asynchronously).
